// File: rtl/imem_rom.sv
`default_nettype none
// ============================================================================
// Module   : imem_rom
// Summary  : 64-word instruction ROM with a combinational read path, a
//            registered copy of the fetched word and an unprogrammed flag.
// Revision : 1.0
// ============================================================================
module imem_rom #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   addr,
    output logic [N-1:0] q,
    output logic [N-1:0] q_r,
    output logic         unprog
);

    localparam logic [5:0] c_LAST_PROG = 6'd46;

    logic [31:0]  w_word;
    logic [N-1:0] r_q_r;

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        logic [31:0] v;
        case (a)
            6'd0:  v = 32'hf8000001;
            6'd1:  v = 32'hf8008002;
            6'd2:  v = 32'hf8000203;
            6'd3:  v = 32'h8b050083;
            6'd4:  v = 32'hf8018003;
            6'd5:  v = 32'hcb050083;
            6'd6:  v = 32'hf8020003;
            6'd7:  v = 32'hcb0a03e4;
            6'd8:  v = 32'hf8028004;
            6'd9:  v = 32'h8b040064;
            6'd10: v = 32'hf8030004;
            6'd11: v = 32'hcb030025;
            6'd12: v = 32'hf8038005;
            6'd13: v = 32'h8a1f0145;
            6'd14: v = 32'hf8040005;
            6'd15: v = 32'h8a030145;
            6'd16: v = 32'hf8048005;
            6'd17: v = 32'h8a140294;
            6'd18: v = 32'hf8050014;
            6'd19: v = 32'haa1f0166;
            6'd20: v = 32'hf8058006;
            6'd21: v = 32'haa030166;
            6'd22: v = 32'hf8060006;
            6'd23: v = 32'hf840000c;
            6'd24: v = 32'h8b1f0187;
            6'd25: v = 32'hf8068007;
            6'd26: v = 32'hf807000c;
            6'd27: v = 32'h8b0e01bf;
            6'd28: v = 32'hf807801f;
            6'd29: v = 32'hb4000040;
            6'd30: v = 32'hf8080015;
            6'd31: v = 32'hf8088015;
            6'd32: v = 32'h8b0103e2;
            6'd33: v = 32'hcb010042;
            6'd34: v = 32'h8b0103f8;
            6'd35: v = 32'hf8090018;
            6'd36: v = 32'h8b080000;
            6'd37: v = 32'hb4ffff82;
            6'd38: v = 32'hf809001e;
            6'd39: v = 32'h8b1e03de;
            6'd40: v = 32'hcb1503f5;
            6'd41: v = 32'h8b1403de;
            6'd42: v = 32'hf85f83d9;
            6'd43: v = 32'h8b1e03de;
            6'd44: v = 32'h8b1003de;
            6'd45: v = 32'hf81f83d9;
            6'd46: v = 32'hb400001f;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    assign w_word = rom_word(addr);

    // Contents are defined as 32-bit words; adapt them to the configured width.
    generate
        if (N > 32) begin : g_zext
            assign q = {{(N-32){1'b0}}, w_word};
        end else begin : g_trunc
            assign q = w_word[N-1:0];
        end
    endgenerate

    assign unprog = (addr > c_LAST_PROG);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q_r <= '0;
        end else begin
            r_q_r <= q;
        end
    end

    assign q_r = r_q_r;

endmodule
`default_nettype wire

// File: tb/tb_imem_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_rom
// Summary  : Self-checking bench for imem_rom: table model plus directed vectors.
// Revision : 1.0
// ============================================================================
module tb_imem_rom;

    localparam int N = 32;

    localparam logic [31:0] EXP [0:46] = '{
        32'hf8000001, 32'hf8008002, 32'hf8000203, 32'h8b050083,
        32'hf8018003, 32'hcb050083, 32'hf8020003, 32'hcb0a03e4,
        32'hf8028004, 32'h8b040064, 32'hf8030004, 32'hcb030025,
        32'hf8038005, 32'h8a1f0145, 32'hf8040005, 32'h8a030145,
        32'hf8048005, 32'h8a140294, 32'hf8050014, 32'haa1f0166,
        32'hf8058006, 32'haa030166, 32'hf8060006, 32'hf840000c,
        32'h8b1f0187, 32'hf8068007, 32'hf807000c, 32'h8b0e01bf,
        32'hf807801f, 32'hb4000040, 32'hf8080015, 32'hf8088015,
        32'h8b0103e2, 32'hcb010042, 32'h8b0103f8, 32'hf8090018,
        32'h8b080000, 32'hb4ffff82, 32'hf809001e, 32'h8b1e03de,
        32'hcb1503f5, 32'h8b1403de, 32'hf85f83d9, 32'h8b1e03de,
        32'h8b1003de, 32'hf81f83d9, 32'hb400001f
    };

    logic         clk;
    logic         reset;
    logic [5:0]   addr;
    logic [N-1:0] q;
    logic [N-1:0] q_r;
    logic         unprog;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_qr;
    logic        m_valid = 1'b0;

    imem_rom #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .q      (q),
        .q_r    (q_r),
        .unprog (unprog)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [31:0] model_q(input logic [5:0] a);
        int i;
        i = int'(a);
        return (i < 47) ? EXP[i] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (addr=%0d t=%0t)", name, act, exp, addr, $time);
        end
    endtask

    // Registered-output model: what q_r must hold after each edge.
    always @(posedge clk) begin
        m_qr    <= reset ? model_q(addr) : 32'h0;
        if (!reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        check("model_q", q, model_q(addr));
        check("model_unprog", {31'b0, unprog}, {31'b0, (int'(addr) >= 47)});
        if (m_valid) check("model_q_r", q_r, m_qr);
    end

    task automatic step(input logic [5:0] a);
        @(posedge clk);
        #1 addr = a;
    endtask

    initial begin
        reset = 1'b0;
        addr  = 6'd5;
        #1;
        check("rst_q_comb", q, 32'hcb050083);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_q_r", q_r, 32'h0);
        check("rst_q", q, 32'hcb050083);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("release_q_r", q_r, 32'hcb050083);

        for (int i = 0; i < 64; i++) begin
            step(6'(i));
            #1;
            if (i == 0)  check("lit_0",  q, 32'hf8000001);
            if (i == 23) check("lit_23", q, 32'hf840000c);
            if (i == 37) check("lit_37", q, 32'hb4ffff82);
            if (i == 46) check("lit_46", q, 32'hb400001f);
            if (i == 47) check("lit_47_unprog", {31'b0, unprog}, 32'h1);
            if (i == 63) check("lit_63", q, 32'h0);
        end

        step(6'd29);
        #1 check("lit_29", q, 32'hb4000040);
        step(6'd30);
        check("lag_q_r_29", q_r, 32'hb4000040);
        #1 check("lit_30", q, 32'hf8080015);
        step(6'd35);
        check("lag_q_r_30", q_r, 32'hf8080015);

        @(posedge clk);
        #1 check("pre_rst_q_r_35", q_r, 32'hf8090018);
        reset = 1'b0;
        addr  = 6'd36;
        #1 check("midrst_q_r_hold", q_r, 32'hf8090018);
        @(posedge clk);
        #1 check("midrst_q_r", q_r, 32'h0);
        check("midrst_q", q, 32'h8b080000);
        addr = 6'd37;
        #1 check("midrst_q_follow", q, 32'hb4ffff82);
        reset = 1'b1;
        @(posedge clk);
        #1 check("resume_q_r", q_r, 32'hb4ffff82);

        for (int i = 0; i < 50; i++) begin
            step(6'(i));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/imem_rom.md
Name: imem_rom

Overview:
- 64-word instruction ROM for the single-cycle processor; the fetch stage drives a 6-bit word address.
- Read path is purely combinational: the instruction is available in the same cycle the address is applied.
- A small clocked side path registers the last fetched word and flags fetches from the unprogrammed region, for debug and trace.

Parameters:
- N, 32, data word width in bits. Contents are defined as 32-bit words: for N>32 each word is zero-extended; for N<32 it is truncated to its low N bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-low reset (0 = reset).
- addr  input  6  word address, 0..63.
- q  output  N  instruction word at addr (combinational).
- q_r  output  N  q registered on the rising clk edge.
- unprog  output  1  combinational; 1 when addr >= 47 (unprogrammed region).

Behaviour:
- Storage: 64 x N read-only words, fixed at elaboration; no write port.
- Read path: q = ROM[addr] combinationally.
  - No clock latency; q settles within the same cycle as addr.
  - Independent of clk and reset; valid during reset.
  - Any X/Z on addr may propagate to q.
- ROM contents, index:value in hex (32-bit):
  - 0:f8000001 1:f8008002 2:f8000203 3:8b050083 4:f8018003 5:cb050083 6:f8020003 7:cb0a03e4
  - 8:f8028004 9:8b040064 10:f8030004 11:cb030025 12:f8038005 13:8a1f0145 14:f8040005 15:8a030145
  - 16:f8048005 17:8a140294 18:f8050014 19:aa1f0166 20:f8058006 21:aa030166 22:f8060006 23:f840000c
  - 24:8b1f0187 25:f8068007 26:f807000c 27:8b0e01bf 28:f807801f 29:b4000040 30:f8080015 31:f8088015
  - 32:8b0103e2 33:cb010042 34:8b0103f8 35:f8090018 36:8b080000 37:b4ffff82 38:f809001e 39:8b1e03de
  - 40:cb1503f5 41:8b1403de 42:f85f83d9 43:8b1e03de 44:8b1003de 45:f81f83d9 46:b400001f
  - 47..63: 00000000
- unprog: 1 iff addr is in 47..63, else 0. Purely combinational, unaffected by reset.
- q_r:
  - On each rising clk edge: if reset==0, q_r <= 0; otherwise q_r <= q, i.e. ROM[addr] sampled at that edge.
  - One-cycle latency relative to q.
  - Power-up value before the first reset edge is undefined. Reset must be held for at least one rising edge.
- Boundaries:
  - Address 63 returns 0; no wrap or aliasing beyond the 6-bit range.
  - Reset asserted mid-operation clears q_r on the next rising edge only; q and unprog keep tracking addr throughout.

Test Plan:
- Hold reset=0 for 2 edges with addr=5 -> q=cb050083 immediately, q_r=00000000. Release reset -> q_r=cb050083 after the next rising edge.
- Sweep addr 0..46, one per cycle; check q 1 ns after each change -> exact table values, e.g. 0:f8000001, 23:f840000c, 37:b4ffff82, 46:b400001f; unprog=0 throughout.
- Sweep addr 47..63 -> q=00000000, unprog=1.
- Drive addr=29 then addr=30 on consecutive edges -> q changes combinationally 29:b4000040 to 30:f8080015; q_r lags by one edge.
- With reset=1, q_r=f8090018 (addr 35), assert reset=0 while stepping addr -> q_r=0 at the next edge while q keeps following addr. Deassert -> q_r resumes tracking.
- Combined sweep addr 0..49 with a 20 ns clock, addr applied 1 ns after the rising edge, checked on the falling edge -> 50 checks, 0 mismatches (addr 47..49 return 0).
